// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RISC-V subset (lw, sw, R-type, I-ALU, jal, beq).
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap on unsupported opcodes; otherwise they return to FETCH.
module multicycle_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        zero,
  output logic        PC_write,
  output logic        adr_select,
  output logic        mem_write,
  output logic        IR_write,
  output logic        reg_write,
  output logic [1:0]  result_select,
  output logic [1:0]  ALU_src_A,
  output logic [1:0]  ALU_src_B,
  output logic [2:0]  ALU_control,
  output logic [1:0]  immediate_select,
  output logic        illegal,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t      r_state;
  state_t      w_next_state;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_funct7b5;
  logic [2:0]  w_alu_decoded;
  logic        w_pc_write;
  logic        w_mem_write;
  logic        w_ir_write;
  logic        w_reg_write;
  logic        w_unused;

  assign w_opcode   = instruction[6:0];
  assign w_funct3   = instruction[14:12];
  assign w_funct7b5 = instruction[30];
  assign w_unused   = &{instruction[31], instruction[29:15], instruction[11:7]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // Instruction is only consulted for branching in DECODE and MEMADR.
  always_comb begin
    w_next_state = S_FETCH;
    unique case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        case (w_opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_R:         w_next_state = S_EXECUTER;
          OP_IALU:      w_next_state = S_EXECUTEI;
          OP_JAL:       w_next_state = S_JAL;
          OP_BEQ:       w_next_state = S_BEQ;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:      w_next_state = S_TRAP;
`else
          default:      w_next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   w_next_state = (w_opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next_state = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL: w_next_state = S_ALUWB;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP:     w_next_state = S_TRAP;
`endif
      default:    w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    w_alu_decoded = ALU_ADD;
    case (w_funct3)
      3'b000:  w_alu_decoded = (w_opcode == OP_R && w_funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_alu_decoded = ALU_SLT;
      3'b110:  w_alu_decoded = ALU_OR;
      3'b111:  w_alu_decoded = ALU_AND;
      default: w_alu_decoded = ALU_ADD;
    endcase
  end

  always_comb begin
    case (w_opcode)
      OP_SW:   immediate_select = 2'b01;
      OP_BEQ:  immediate_select = 2'b10;
      OP_JAL:  immediate_select = 2'b11;
      default: immediate_select = 2'b00;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred for unlisted states.
  always_comb begin
    w_pc_write    = 1'b0;
    adr_select    = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_write   = 1'b0;
    result_select = 2'b00;
    ALU_src_A     = 2'b00;
    ALU_src_B     = 2'b00;
    ALU_control   = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_ir_write    = 1'b1;
        ALU_src_B     = 2'b10;
        result_select = 2'b10;
        w_pc_write    = 1'b1;
      end
      S_DECODE: begin
        ALU_src_A = 2'b01;
        ALU_src_B = 2'b01;
      end
      S_MEMADR: begin
        ALU_src_A = 2'b10;
        ALU_src_B = 2'b01;
      end
      S_MEMREAD:  adr_select = 1'b1;
      S_MEMWRITE: begin
        adr_select  = 1'b1;
        w_mem_write = 1'b1;
      end
      S_MEMWB: begin
        result_select = 2'b01;
        w_reg_write   = 1'b1;
      end
      S_ALUWB: w_reg_write = 1'b1;
      S_EXECUTER: begin
        ALU_src_A   = 2'b10;
        ALU_control = w_alu_decoded;
      end
      S_EXECUTEI: begin
        ALU_src_A   = 2'b10;
        ALU_src_B   = 2'b01;
        ALU_control = w_alu_decoded;
      end
      S_JAL: begin
        ALU_src_A  = 2'b01;
        ALU_src_B  = 2'b10;
        w_pc_write = 1'b1;
      end
      S_BEQ: begin
        ALU_src_A   = 2'b10;
        ALU_control = ALU_SUB;
        w_pc_write  = zero;
      end
      default: ;
    endcase
  end

  // Write strobes are held off for the whole reset cycle, whatever state is still showing.
  assign PC_write  = w_pc_write  & ~reset;
  assign mem_write = w_mem_write & ~reset;
  assign IR_write  = w_ir_write  & ~reset;
  assign reg_write = w_reg_write & ~reset;
  assign state     = r_state;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign illegal = (r_state == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state changes occur on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset, sampled on rising clock.
REQ-003 SHALL have port instruction, input, 32, current instruction register contents; uses opcode [6:0], funct3 [14:12] and funct7b5 [30].
REQ-004 SHALL have port zero, input, 1, ALU zero flag from the datapath.
REQ-005 SHALL have outputs PC_write (1), adr_select (1), mem_write (1), IR_write (1) and reg_write (1), all active-high write/select strobes to the datapath and memory.
REQ-006 SHALL have outputs result_select (2), ALU_src_A (2), ALU_src_B (2), ALU_control (3) and immediate_select (2), the datapath mux and ALU controls.
REQ-007 SHALL have outputs illegal (1), sticky illegal-opcode flag, and state (4), current FSM state for debug.

Function
REQ-008 SHALL be a Moore FSM with a 4-bit state register; all outputs SHALL be combinational from state, instruction and zero only.
REQ-009 SHALL use state encoding FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10, TRAP=11.
REQ-010 SHALL decode opcodes lw=0000011, sw=0100011, R=0110011, I-ALU=0010011, jal=1101111, beq=1100011; every other opcode is unsupported.
REQ-011 SHALL use these transitions: FETCH->DECODE; DECODE->MEMADR (lw, sw), EXECUTER (R), EXECUTEI (I-ALU), JAL (jal), BEQ (beq); MEMADR->MEMREAD (lw) or MEMWRITE (sw).
REQ-012 SHALL also use these transitions: MEMREAD->MEMWB; EXECUTER, EXECUTEI, JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BEQ->FETCH.
REQ-013 SHALL drive in FETCH: IR_write=1, adr_select=0, ALU_src_A=00, ALU_src_B=10, ALU add, result_select=10, PC_write=1.
REQ-014 SHALL drive in DECODE: ALU_src_A=01, ALU_src_B=01, ALU add.
REQ-015 SHALL drive in MEMADR: ALU_src_A=10, ALU_src_B=01, ALU add.
REQ-016 SHALL drive adr_select=1 and result_select=00 in MEMREAD and MEMWRITE, plus mem_write=1 in MEMWRITE only.
REQ-017 SHALL drive result_select=01 with reg_write=1 in MEMWB, and result_select=00 with reg_write=1 in ALUWB.
REQ-018 SHALL drive ALU_src_A=10 and funct-decoded ALU in EXECUTER (ALU_src_B=00) and EXECUTEI (ALU_src_B=01).
REQ-019 SHALL drive in JAL: ALU_src_A=01, ALU_src_B=10, ALU add, result_select=00, PC_write=1.
REQ-020 SHALL drive in BEQ: ALU_src_A=10, ALU_src_B=00, ALU sub, result_select=00, PC_write=zero.
REQ-021 SHALL drive all unlisted outputs as 0 in every state.
REQ-022 SHALL encode ALU_control as add=000, sub=001, and=010, or=011, slt=101.
REQ-023 SHALL decode funct3 as: 000 -> sub if R-type and funct7b5=1, else add; 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
REQ-024 SHALL set immediate_select from opcode in every state: sw=01, beq=10, jal=11, all others=00.
REQ-025 SHALL sample instruction in DECODE and MEMADR only; any change in other states SHALL NOT alter the path taken.

Reset
REQ-026 SHALL load state=FETCH and clear illegal on any rising edge with reset=1, including mid-instruction.
REQ-027 SHALL force PC_write, mem_write, reg_write and IR_write to 0 while reset=1, regardless of state.
REQ-028 SHALL begin the first FETCH in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL compile the trap path only when macro MULTICYCLE_ILLEGAL_TRAP_EN is defined.
REQ-030 SHALL, with MULTICYCLE_ILLEGAL_TRAP_EN defined: unsupported opcode in DECODE -> TRAP; TRAP holds until reset; TRAP drives all strobes 0; illegal=1 from TRAP entry.
REQ-031 SHALL, without MULTICYCLE_ILLEGAL_TRAP_EN: unsupported opcode in DECODE -> FETCH; illegal tied to 0; TRAP encoding unused.

Verification
REQ-032 SHALL cover: reset, then lw 0x00402283 -> states 0,1,2,3,4,0; reg_write=1 only in MEMWB; result_select=01 in MEMWB.
REQ-033 SHALL cover: sw 0x00502223 -> states 0,1,2,5,0; mem_write=1 for exactly one cycle; immediate_select=01.
REQ-034 SHALL cover: R-type sub 0x40B50533 -> states 0,1,6,7,0; ALU_control=001 in EXECUTER; ALU_control=000 for add 0x00B50533.
REQ-035 SHALL cover: beq 0xFE420AE3 with zero=1 -> PC_write=1 in BEQ; with zero=0 -> PC_write=0; then returns to FETCH.
REQ-036 SHALL cover: opcode 0x0000007F -> with macro, TRAP with illegal=1 held 20 cycles until reset clears both; without macro, FETCH next cycle with illegal=0.
REQ-037 SHALL cover: reset asserted in MEMWRITE -> mem_write=0 that cycle and state=FETCH next cycle.
